seq_multiplier: RTL and testbench

//  Parametrised multi-cycle shift-add multiplier for the MIPS datapath; successor to combinational multiplier.

---
 rtl/mult_pkg.sv | 13 +
 rtl/mult_negate.sv | 12 +
 rtl/seq_multiplier.sv | 145 ++++++++++++++
 tb/tb_seq_multiplier.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    MULT_IDLE,
    MULT_BUSY,
    MULT_FIX,
    MULT_DONE
  } mult_state_t;

  localparam int MULT_WIDTH_DEF = 32;

endpackage

// File: rtl/mult_negate.sv
// Combinational conditional two's-complement negate: o_out = i_neg ? -i_in : i_in.
module mult_negate #(
  parameter int N = 32
) (
  input  logic [N-1:0] i_in,
  input  logic         i_neg,
  output logic [N-1:0] o_out
);

  assign o_out = i_neg ? (~i_in + N'(1)) : i_in;

endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier producing a 2*WIDTH-bit signed/unsigned product.
// Optional build macro MULT_EARLY_TERM_EN: leave BUSY as soon as the remaining multiplier bits are zero.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH          = MULT_WIDTH_DEF,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             inpStart,
  input  logic             inpSigned,
  input  logic [WIDTH-1:0] inpMultA,
  input  logic [WIDTH-1:0] inpMultB,
  output logic [WIDTH-1:0] outMultHi,
  output logic [WIDTH-1:0] outMultLo,
  output logic             outBusy,
  output logic             outDone
);

  localparam int PW    = 2 * WIDTH;
  localparam int ITERS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(ITERS + 1);
  localparam logic [CNT_W-1:0] ITERS_CNT = CNT_W'(ITERS);

  if (!((BITS_PER_CYCLE == 1) || (BITS_PER_CYCLE == 2) || (BITS_PER_CYCLE == 4)) ||
      ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_bad_cfg
    $error("seq_multiplier: BITS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH");
  end

  mult_state_t      r_state;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CNT_W-1:0] r_iter_cnt;
  logic             r_neg;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;

  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [PW-1:0]    w_result;
  logic [PW-1:0]    w_pp_terms [BITS_PER_CYCLE];
  logic [PW-1:0]    w_pp_sum;
  logic [WIDTH-1:0] w_mplier_next;
  logic             w_last;

  mult_negate #(.N(WIDTH)) u_neg_a (
    .i_in  (inpMultA),
    .i_neg (inpSigned & inpMultA[WIDTH-1]),
    .o_out (w_abs_a)
  );

  mult_negate #(.N(WIDTH)) u_neg_b (
    .i_in  (inpMultB),
    .i_neg (inpSigned & inpMultB[WIDTH-1]),
    .o_out (w_abs_b)
  );

  mult_negate #(.N(PW)) u_neg_p (
    .i_in  (r_acc),
    .i_neg (r_neg),
    .o_out (w_result)
  );

  // One shifted copy of the multiplicand per multiplier bit retired this cycle.
  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
    assign w_pp_terms[gi] = r_mplier[gi] ? (r_mcand << gi) : '0;
  end

  always_comb begin
    w_pp_sum = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      w_pp_sum = w_pp_sum + w_pp_terms[i];
    end
  end

  assign w_mplier_next = r_mplier >> BITS_PER_CYCLE;

`ifdef MULT_EARLY_TERM_EN
  assign w_last = (r_iter_cnt == CNT_W'(1)) || (w_mplier_next == '0);
`else
  assign w_last = (r_iter_cnt == CNT_W'(1));
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state    <= MULT_IDLE;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_iter_cnt <= '0;
      r_neg      <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        MULT_IDLE: begin
          if (inpStart) begin
            r_neg      <= inpSigned & (inpMultA[WIDTH-1] ^ inpMultB[WIDTH-1]);
            r_acc      <= '0;
            r_mcand    <= {{WIDTH{1'b0}}, w_abs_a};
            r_mplier   <= w_abs_b;
            r_iter_cnt <= ITERS_CNT;
            r_busy     <= 1'b1;
            r_state    <= MULT_BUSY;
          end
        end
        MULT_BUSY: begin
          r_acc      <= r_acc + w_pp_sum;
          r_mcand    <= r_mcand << BITS_PER_CYCLE;
          r_mplier   <= w_mplier_next;
          r_iter_cnt <= r_iter_cnt - CNT_W'(1);
          if (w_last) begin
            r_state <= MULT_FIX;
          end
        end
        MULT_FIX: begin
          r_hi    <= w_result[PW-1:WIDTH];
          r_lo    <= w_result[WIDTH-1:0];
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= MULT_DONE;
        end
        MULT_DONE: begin
          r_state <= MULT_IDLE;
        end
        default: begin
          r_state <= MULT_IDLE;
        end
      endcase
    end
  end

  assign outMultHi = r_hi;
  assign outMultLo = r_lo;
  assign outBusy   = r_busy;
  assign outDone   = r_done;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed table-driven bench for seq_multiplier (WIDTH=32, BITS_PER_CYCLE=1).
module tb_seq_multiplier;

  localparam int W = 32;

  logic         clk       = 1'b0;
  logic         resetN    = 1'b1;
  logic         inpStart  = 1'b0;
  logic         inpSigned = 1'b0;
  logic [W-1:0] inpMultA  = '0;
  logic [W-1:0] inpMultB  = '0;
  logic [W-1:0] outMultHi;
  logic [W-1:0] outMultLo;
  logic         outBusy;
  logic         outDone;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_multiplier #(.WIDTH(W), .BITS_PER_CYCLE(1)) dut (
    .clk       (clk),
    .resetN    (resetN),
    .inpStart  (inpStart),
    .inpSigned (inpSigned),
    .inpMultA  (inpMultA),
    .inpMultB  (inpMultB),
    .outMultHi (outMultHi),
    .outMultLo (outMultLo),
    .outBusy   (outBusy),
    .outDone   (outDone)
  );

  typedef struct {
    logic         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic sgn, input logic [W-1:0] a, b, hi, lo);
    vec_t v;
    v.sgn = sgn; v.a = a; v.b = b; v.hi = hi; v.lo = lo;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Latency counts rising edges from the accept edge (1) up to the edge that raises outDone.
  function automatic int exp_lat(input logic sgn, input logic [W-1:0] b);
`ifdef MULT_EARLY_TERM_EN
    logic [W-1:0] m;
    int bl;
    m  = (sgn && b[W-1]) ? (~b + 1) : b;
    bl = 0;
    for (int i = 0; i < W; i++) if (m[i]) bl = i + 1;
    return ((bl < 1) ? 1 : bl) + 2;
`else
    return W + 2;
`endif
  endfunction

  task automatic wait_done(inout int lat);
    while (!outDone && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input logic sgn, input logic [W-1:0] a, b,
                        output logic [63:0] prod, output int lat);
    @(negedge clk);
    inpSigned = sgn; inpMultA = a; inpMultB = b; inpStart = 1'b1;
    @(posedge clk); #1;
    inpStart = 1'b0;
    lat = 1;
    wait_done(lat);
    prod = {outMultHi, outMultLo};
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] prod;
    int          lat;
    bit          seen_done;

    add_vec(1'b1, 32'd2,          32'd4,          32'h0000_0000, 32'h0000_0008);
    add_vec(1'b1, 32'd2,          32'd3,          32'h0000_0000, 32'h0000_0006);
    add_vec(1'b1, 32'd2,          32'hFFFF_FFFC,  32'hFFFF_FFFF, 32'hFFFF_FFF8);
    add_vec(1'b1, 32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF, 32'hFFFF_FFFA);
    add_vec(1'b1, 32'hFFFF_FFFE,  32'hFFFF_FFFC,  32'h0000_0000, 32'h0000_0008);
    add_vec(1'b1, 32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'h0000_0000, 32'h0000_0006);
    add_vec(1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001);
    add_vec(1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 32'h0000_0001);
    add_vec(1'b1, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 32'h0000_0000);
    add_vec(1'b1, 32'd0,          32'd12345,      32'h0000_0000, 32'h0000_0000);
    add_vec(1'b0, 32'hDEAD_BEEF,  32'd0,          32'h0000_0000, 32'h0000_0000);
    add_vec(1'b1, 32'h8000_0000,  32'd1,          32'hFFFF_FFFF, 32'h8000_0000);
    add_vec(1'b0, 32'h8000_0000,  32'd2,          32'h0000_0001, 32'h0000_0000);
    add_vec(1'b0, 32'h0001_0000,  32'h0001_0000,  32'h0000_0001, 32'h0000_0000);
    add_vec(1'b1, 32'd1,          32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
    add_vec(1'b0, 32'h0000_FFFF,  32'h0000_FFFF,  32'h0000_0000, 32'hFFFE_0001);
    add_vec(1'b1, 32'd7,          32'hFFFF_FFFB,  32'hFFFF_FFFF, 32'hFFFF_FFDD);

    // Asynchronous reset before any clock edge
    #2 resetN = 1'b0;
    #1;
    check("reset_hilo", {outMultHi, outMultLo}, 64'h0);
    check("reset_busy_done", {62'h0, outBusy, outDone}, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) resetN = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].sgn, vecs[i].a, vecs[i].b, prod, lat);
      $display("[TB] op %0d sgn=%0b a=%h b=%h -> %h lat=%0d", i, vecs[i].sgn,
               vecs[i].a, vecs[i].b, prod, lat);
      check($sformatf("vec%0d_product", i), prod, {vecs[i].hi, vecs[i].lo});
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat(vecs[i].sgn, vecs[i].b)));
      check($sformatf("vec%0d_busy_in_done", i), {63'h0, outBusy}, 64'h0);
      @(posedge clk); #1;
      check($sformatf("vec%0d_done_pulse", i), {63'h0, outDone}, 64'h0);
    end

    // Start held high: second request waits until after DONE; mid-op operand change ignored
    @(negedge clk);
    inpSigned = 1'b0; inpMultA = 32'd3; inpMultB = 32'd5; inpStart = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    check("hs_busy_after_accept", {63'h0, outBusy}, 64'h1);
    repeat (2) begin @(posedge clk); #1; lat++; end
    inpMultA = 32'd7; inpMultB = 32'd6;
    wait_done(lat);
    $display("[TB] handshake op1 -> %h lat=%0d", {outMultHi, outMultLo}, lat);
    check("hs_op1_product", {outMultHi, outMultLo}, 64'd15);
    check("hs_op1_latency", 64'(lat), 64'(exp_lat(1'b0, 32'd5)));
    @(posedge clk); #1;
    check("hs_start_ignored_in_done", {62'h0, outBusy, outDone}, 64'h0);
    @(posedge clk); #1;
    check("hs_start_accepted_after_done", {63'h0, outBusy}, 64'h1);
    inpStart = 1'b0;
    lat = 1;
    wait_done(lat);
    $display("[TB] handshake op2 -> %h lat=%0d", {outMultHi, outMultLo}, lat);
    check("hs_op2_product", {outMultHi, outMultLo}, 64'd42);
    check("hs_op2_latency", 64'(lat), 64'(exp_lat(1'b0, 32'd6)));
    @(posedge clk); #1;

    // Reset in the middle of an operation
    @(negedge clk);
    inpSigned = 1'b1; inpMultA = 32'h1234_5678; inpMultB = 32'h7FFF_FFFF; inpStart = 1'b1;
    @(posedge clk); #1;
    inpStart = 1'b0;
    repeat (9) @(posedge clk);
    #1 resetN = 1'b0;
    #1;
    check("midrst_hilo", {outMultHi, outMultLo}, 64'h0);
    check("midrst_busy_done", {62'h0, outBusy, outDone}, 64'h0);
    seen_done = 1'b0;
    repeat (3) begin @(posedge clk); #1; if (outDone) seen_done = 1'b1; end
    @(negedge clk) resetN = 1'b1;
    repeat (40) begin @(posedge clk); #1; if (outDone) seen_done = 1'b1; end
    check("midrst_no_done", {63'h0, seen_done}, 64'h0);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd9, prod, lat);
    $display("[TB] post-reset op -> %h lat=%0d", prod, lat);
    check("postrst_product", prod, 64'hFFFF_FFFF_FFFF_FFC1);
    check("postrst_latency", 64'(lat), 64'(exp_lat(1'b1, 32'd9)));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
